core: RTL and testbench

Minimal 8-bit multi-master CPU core sitting on a shared, arbitrated byte bus with a 512-byte address space. It fetches 32-bit big-endian instructions one byte at a time through a request/grant handshake, then decodes and executes them against a 16 x 8-bit register file. An external arbiter and memory model complete the system. Benches poke internal registers `IR` and `state` hierarchically, so both names and encodings are fixed.

---
 rtl/core_pkg.sv | 52 +++++
 rtl/core_alu.sv | 23 ++
 rtl/core.sv | 136 +++++++++++++
 tb/tb_core.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the byte-bus CPU core: state encoding, opcodes
// and instruction field helpers.
package core_pkg;

    typedef enum logic [3:0] {
        FETCH0 = 4'd0,
        FETCH1 = 4'd1,
        FETCH2 = 4'd2,
        FETCH3 = 4'd3,
        EXEC   = 4'd4,
        MEM    = 4'd5,
        HALT   = 4'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic [3:0] f_op(input logic [31:0] ir);
        return ir[31:28];
    endfunction

    function automatic logic [3:0] f_rd(input logic [31:0] ir);
        return ir[27:24];
    endfunction

    function automatic logic [3:0] f_ra(input logic [31:0] ir);
        return ir[23:20];
    endfunction

    function automatic logic [3:0] f_rb(input logic [31:0] ir);
        return ir[19:16];
    endfunction

    function automatic logic [7:0] f_imm(input logic [31:0] ir);
        return ir[7:0];
    endfunction

    function automatic logic [8:0] f_a9(input logic [31:0] ir);
        return ir[8:0];
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational 8-bit ALU; results wrap, no flags are produced.
module core_alu
    import core_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/core.sv
// 8-bit CPU core on a shared arbitrated byte bus: byte-serial big-endian
// fetch, single-cycle execute, one bus cycle for loads and stores.
module core
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       grant_given,
    output logic       grant_request,
    output logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [8:0] address
);

    // Bus handshake: a byte moves on a rising edge where grant_request and
    // grant_given are both high; the request and its address/rw/data are held
    // stable until then, and grant_given without a request is ignored.
    logic [31:0] IR;
    state_t      state;
    logic [8:0]  PC;
    logic [7:0]  R [16];

    state_t      state_d;
    logic [31:0] ir_d;
    logic [8:0]  pc_d;
    logic        reg_we;
    logic [3:0]  reg_wa;
    logic [7:0]  reg_wd;
    logic        xfer;
    logic [7:0]  alu_y;
    logic        req_d;
    logic        rw_d;
    logic [8:0]  addr_d;
    logic [7:0]  dout_d;

    assign xfer = grant_request & grant_given;

    core_alu u_alu (
        .op (f_op(IR)),
        .a  (R[f_ra(IR)]),
        .b  (R[f_rb(IR)]),
        .y  (alu_y)
    );

    always_comb begin
        state_d = state;
        ir_d    = IR;
        pc_d    = PC;
        reg_we  = 1'b0;
        reg_wa  = f_rd(IR);
        reg_wd  = alu_y;
        case (state)
            FETCH0, FETCH1, FETCH2, FETCH3: begin
                if (xfer) begin
                    // FETCHn fills byte 3-n, i.e. the inverted low state bits
                    ir_d[{~state[1:0], 3'b000} +: 8] = data_in;
                    state_d = (state == FETCH3) ? EXEC : state_t'(state + 4'd1);
                end
            end
            EXEC: begin
                pc_d    = PC + 9'd4;
                state_d = FETCH0;
                case (f_op(IR))
                    OP_LDI: begin
                        reg_we = 1'b1;
                        reg_wd = f_imm(IR);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: reg_we = 1'b1;
                    OP_LD, OP_ST: begin
                        pc_d    = PC;
                        state_d = MEM;
                    end
                    OP_JMP:  pc_d = f_a9(IR);
                    OP_BEQZ: if (R[f_ra(IR)] == 8'h00) pc_d = f_a9(IR);
                    OP_HALT: state_d = HALT;
                    default: ;
                endcase
            end
            MEM: begin
                if (xfer) begin
                    pc_d    = PC + 9'd4;
                    state_d = FETCH0;
                    if (f_op(IR) == OP_LD) begin
                        reg_we = 1'b1;
                        reg_wd = data_in;
                    end
                end
            end
            HALT:    ;
            default: state_d = FETCH0;
        endcase

        // Bus outputs are registered from the state being entered
        req_d  = 1'b0;
        rw_d   = 1'b0;
        addr_d = 9'h000;
        dout_d = 8'h00;
        case (state_d)
            FETCH0, FETCH1, FETCH2, FETCH3: begin
                req_d  = 1'b1;
                addr_d = pc_d + {7'd0, state_d[1:0]};
            end
            MEM: begin
                req_d  = 1'b1;
                addr_d = f_a9(ir_d);
                rw_d   = (f_op(ir_d) == OP_ST);
                dout_d = rw_d ? R[f_rd(ir_d)] : 8'h00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= FETCH0;
            IR            <= 32'h0;
            PC            <= 9'h000;
            grant_request <= 1'b0;
            rw            <= 1'b0;
            address       <= 9'h000;
            data_out      <= 8'h00;
            for (int i = 0; i < 16; i++) R[i] <= 8'h00;
        end else begin
            state         <= state_d;
            IR            <= ir_d;
            PC            <= pc_d;
            grant_request <= req_d;
            rw            <= rw_d;
            address       <= addr_d;
            data_out      <= dout_d;
            if (reg_we) R[reg_wa] <= reg_wd;
        end
    end

endmodule

// File: tb/tb_core.sv
// Bench for core: directed timing scenarios plus random programs checked
// against an instruction-level interpreter and a store scoreboard.
module tb_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       grant_given = 1'b0;
    logic       grant_request;
    logic       rw;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [8:0] address;

    logic [7:0]  mem   [512];
    logic [7:0]  m_mem [512];
    logic [7:0]  m_r   [16];
    logic [8:0]  m_pc;
    logic [16:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    bit rand_grant = 1'b0;
    bit sb_on = 1'b0;

    always #5 clk = ~clk;

    core dut (
        .clk           (clk),
        .reset         (reset),
        .grant_given   (grant_given),
        .grant_request (grant_request),
        .rw            (rw),
        .data_in       (data_in),
        .data_out      (data_out),
        .address       (address)
    );

    assign data_in = mem[address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n cycles; called and returning at a falling edge.
    task automatic step(input int n);
        logic [16:0] e;
        repeat (n) begin
            if (rand_grant) grant_given = ($urandom_range(0, 3) != 0);
            #1;
            if (reset && grant_request && grant_given && rw) begin
                mem[address] = data_out;
                if (sb_on) begin
                    check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("wr_txn", {15'd0, address, data_out}, {15'd0, e});
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        grant_given = 1'b0;
        step(3);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [8:0] lo);
        return {op, rd, ra, rb, 7'd0, lo};
    endfunction

    task automatic put_word(input logic [8:0] a, input logic [31:0] w);
        mem[a]        = w[31:24];
        mem[a + 9'd1] = w[23:16];
        mem[a + 9'd2] = w[15:8];
        mem[a + 9'd3] = w[7:0];
    endtask

    // Instruction-level interpreter of the ISA; stores feed the scoreboard.
    task automatic model_run();
        logic [8:0]  pc;
        logic [31:0] w;
        logic [3:0]  op, rd, ra, rb;
        logic [8:0]  a9;
        bit          done;
        pc = 9'h000;
        done = 1'b0;
        for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
        for (int i = 0; i < 512; i++) m_mem[i] = mem[i];
        for (int s = 0; s < 300 && !done; s++) begin
            w  = {m_mem[pc], m_mem[pc + 9'd1], m_mem[pc + 9'd2], m_mem[pc + 9'd3]};
            op = w[31:28]; rd = w[27:24]; ra = w[23:20]; rb = w[19:16]; a9 = w[8:0];
            case (op)
                4'h1: m_r[rd] = w[7:0];
                4'h2: m_r[rd] = m_r[ra] + m_r[rb];
                4'h3: m_r[rd] = m_r[ra] - m_r[rb];
                4'h4: m_r[rd] = m_r[ra] & m_r[rb];
                4'h5: m_r[rd] = m_r[ra] | m_r[rb];
                4'h6: m_r[rd] = m_r[ra] ^ m_r[rb];
                4'h7: m_r[rd] = m_mem[a9];
                4'h8: begin
                    m_mem[a9] = m_r[rd];
                    exp_q.push_back({a9, m_r[rd]});
                end
                4'hF: done = 1'b1;
                default: ;
            endcase
            if (op == 4'h9) pc = a9;
            else if (op == 4'hA && m_r[ra] == 8'h00) pc = a9;
            else pc = pc + 9'd4;
        end
        m_pc = pc;
    endtask

    task automatic random_program(input int seed_tag);
        logic [3:0] op;
        logic [8:0] lo;
        int         n;
        int         budget;
        n = 16;
        for (int i = 0; i < 512; i++) mem[i] = (i >= 256) ? 8'($urandom) : 8'h00;
        for (int i = 0; i < n - 1; i++) begin
            op = 4'($urandom_range(0, 11));
            lo = 9'($urandom);
            if (op == 4'h7 || op == 4'h8) lo = 9'h100 + 9'($urandom_range(0, 255));
            if (op == 4'h9 || op == 4'hA) lo = 9'(4 * $urandom_range(i + 1, n - 1));
            if (op == 4'h1) lo = {1'b0, 8'($urandom)};
            put_word(9'(4 * i), enc(op, 4'($urandom), 4'($urandom), 4'($urandom), lo));
        end
        put_word(9'(4 * (n - 1)), enc(4'hF, 4'h0, 4'h0, 4'h0, 9'h0));
        exp_q.delete();
        model_run();
        do_reset();
        rand_grant = 1'b1;
        sb_on = 1'b1;
        budget = 0;
        while (dut.state != 4'd6 && budget < 5000) begin
            step(1);
            budget++;
        end
        rand_grant = 1'b0;
        sb_on = 1'b0;
        check($sformatf("rnd%0d_halt", seed_tag), 32'(dut.state), 32'd6);
        check($sformatf("rnd%0d_pc", seed_tag), 32'(dut.PC), 32'(m_pc));
        check($sformatf("rnd%0d_wr_left", seed_tag), 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 16; i++)
            check($sformatf("rnd%0d_r%0d", seed_tag, i), 32'(dut.R[i]), 32'(m_r[i]));
        for (int i = 256; i < 512; i++)
            if (mem[i] !== m_mem[i])
                check($sformatf("rnd%0d_mem%0h", seed_tag, i), 32'(mem[i]), 32'(m_mem[i]));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        put_word(9'h000, 32'h0000_0000);
        put_word(9'h004, 32'h1300_002A);
        put_word(9'h008, 32'h1100_00F0);
        put_word(9'h00C, 32'h1200_0020);
        put_word(9'h010, 32'h2412_0000);
        put_word(9'h014, 32'h8400_01FF);
        put_word(9'h018, 32'h7500_01FF);
        put_word(9'h01C, 32'hF000_0000);

        do_reset();
        check("rst_req", 32'(grant_request), 32'd0);
        check("rst_rw", 32'(rw), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        check("rst_pc", 32'(dut.PC), 32'd0);
        check("rst_ir", dut.IR, 32'd0);

        grant_given = 1'b1;
        step(6);
        check("nop_pc", 32'(dut.PC), 32'h4);
        check("nop_req", 32'(grant_request), 32'd1);
        check("nop_addr", 32'(address), 32'h4);
        check("nop_rw", 32'(rw), 32'd0);
        step(5);
        check("ldi_r3", 32'(dut.R[3]), 32'h2A);
        check("ldi_pc", 32'(dut.PC), 32'h8);
        step(15);
        check("add_r4_wrap", 32'(dut.R[4]), 32'h10);
        step(5);
        check("st_state", 32'(dut.state), 32'd5);
        check("st_req", 32'(grant_request), 32'd1);
        check("st_rw", 32'(rw), 32'd1);
        check("st_addr", 32'(address), 32'h1FF);
        check("st_dout", 32'(data_out), 32'h10);
        step(1);
        check("st_mem", 32'(mem[9'h1FF]), 32'h10);
        step(6);
        check("ld_r5", 32'(dut.R[5]), 32'h10);
        check("ld_pc", 32'(dut.PC), 32'h1C);
        step(5);
        check("halt_state", 32'(dut.state), 32'd6);
        check("halt_req", 32'(grant_request), 32'd0);
        step(3);
        check("halt_hold", 32'(dut.state), 32'd6);

        do_reset();
        grant_given = 1'b1;
        step(3);
        check("stall_pre_state", 32'(dut.state), 32'd2);
        check("stall_pre_addr", 32'(address), 32'h2);
        grant_given = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check("stall_state", 32'(dut.state), 32'd2);
            check("stall_addr", 32'(address), 32'h2);
            check("stall_req", 32'(grant_request), 32'd1);
        end
        grant_given = 1'b1;
        step(1);
        check("resume_state", 32'(dut.state), 32'd3);
        check("resume_addr", 32'(address), 32'h3);

        mem[9'h1FF] = 8'h77;
        do_reset();
        grant_given = 1'b1;
        step(31);
        check("abort_pre_state", 32'(dut.state), 32'd5);
        reset = 1'b0;
        step(1);
        check("abort_state", 32'(dut.state), 32'd0);
        check("abort_req", 32'(grant_request), 32'd0);
        check("abort_pc", 32'(dut.PC), 32'd0);
        check("abort_mem", 32'(mem[9'h1FF]), 32'h77);

        for (int p = 0; p < 4; p++) random_program(p);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
